regfile_write_arbiter: RTL

- Shares the register file's single write port between two writeback requesters:
  - requester 0: ALU writeback
  - requester 1: load unit
- Tracks which architectural registers have an outstanding write, using a 32-entry busy scoreboard.
- Sits between the execute/memory stages and `register_file`, and drives its `wr_ena`/`wr_addr`/`wr_data` directly.
- The issue stage reads the scoreboard to stall instructions whose source registers are still pending.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and widths, used by the write arbiter,
// register_file and the pipeline.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. last_grant names the most recent winner;
// under contention the other requester is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU writeback and the load unit,
// and keeps the busy scoreboard the issue stage uses to stall on pending writes.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]       req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]       req1_data,
  output logic                  req1_ready,
  output logic                  wr_ena,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  input  logic                  reserve_ena,
  input  logic [REG_ADDR_W-1:0] reserve_addr,
  input  logic [REG_ADDR_W-1:0] rs0_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  output logic                  rs0_busy,
  output logic                  rs1_busy
);

  // Handshake: a request transfers on a posedge where valid and ready are both
  // high; ready is combinational and there is no backpressure from the write
  // port. A requester holds valid/addr/data stable until it sees ready.
  logic [1:0]          grant;
  logic                last_grant;
  rf_wr_req_t          sel_req;
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:0] busy_vec;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      ({req1_valid, req0_valid}),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel_req = '{addr: req0_addr, data: req0_data};
    if (grant[1]) begin
      sel_req = '{addr: req1_addr, data: req1_data};
    end
  end

  // x0 writes are accepted and latched but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ena  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (|grant) begin
      wr_ena  <= (sel_req.addr != '0);
      wr_addr <= sel_req.addr;
      wr_data <= sel_req.data;
    end else begin
      wr_ena  <= 1'b0;
    end
  end

  // Reserve has priority over the commit-edge clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (reserve_ena && reserve_addr == REG_ADDR_W'(i)) begin
          busy_q[i] <= 1'b1;
        end else if (wr_ena && wr_addr == REG_ADDR_W'(i)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = {busy_q, 1'b0};
  assign rs0_busy = busy_vec[rs0_addr];
  assign rs1_busy = busy_vec[rs1_addr];

endmodule
